// File: rtl/uart_frame_ctrl_if.sv
// Byte stream from the UART receiver into the frame controller, plus the published command/status.
interface uart_frame_ctrl_if #(
  parameter int PAYLOAD_LEN = 4
);
  logic                     rx_valid;
  logic [7:0]               rx_byte;
  logic                     rx_parity_ok;
  logic                     cmd_valid;
  logic [8*PAYLOAD_LEN-1:0] cmd_payload;
  logic                     frame_err;
  logic [7:0]               err_count;
  logic                     busy;

  modport master (
    output rx_valid, rx_byte, rx_parity_ok,
    input  cmd_valid, cmd_payload, frame_err, err_count, busy
  );

  modport slave (
    input  rx_valid, rx_byte, rx_parity_ok,
    output cmd_valid, cmd_payload, frame_err, err_count, busy
  );
endinterface

// File: rtl/uart_frame_ctrl.sv
// Sequences UART bytes into header/ID/payload/checksum frames; publishes checked payloads 1 clk after
// the checksum byte. No backpressure: every rx_valid byte is consumed in its own cycle.
module uart_frame_ctrl #(
  parameter logic [7:0] HEADER       = 8'hA5,
  parameter logic [7:0] BOT_ID       = 8'h03,
  parameter int         PAYLOAD_LEN  = 4,
  parameter int         TIMEOUT_CLKS = 1000
) (
  input logic             clk,
  input logic             rst,
  uart_frame_ctrl_if.slave bus
);

  localparam int                PW       = 8 * PAYLOAD_LEN;
  localparam int                TW       = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [3:0]        IDX_LAST = 4'(PAYLOAD_LEN - 1);

  typedef enum logic [1:0] {S_HUNT, S_ID, S_PAYLOAD, S_CHECK} state_t;

  state_t          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      csum_q, csum_d;
  logic [PW-1:0]   shadow_q, shadow_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [PW-1:0]   payload_q, payload_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic            frame_err_q, frame_err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    shadow_d    = shadow_q;
    tmo_d       = tmo_q;
    payload_d   = payload_q;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;

    if (bus.rx_valid) begin
      tmo_d = '0;
    end else if (state_q != S_HUNT) begin
      tmo_d = tmo_q + 1'b1;
    end

    case (state_q)
      S_HUNT: begin
        if (bus.rx_valid && bus.rx_parity_ok && bus.rx_byte == HEADER) begin
          state_d = S_ID;
        end
      end
      S_ID: begin
        if (bus.rx_valid) begin
          if (!bus.rx_parity_ok) begin
            frame_err_d = 1'b1;
            state_d     = S_HUNT;
          end else if (bus.rx_byte == BOT_ID || bus.rx_byte == 8'hFF) begin
            csum_d  = bus.rx_byte;
            idx_d   = '0;
            state_d = S_PAYLOAD;
          end else begin
            // Another robot's frame: drop quietly.
            state_d = S_HUNT;
          end
        end
      end
      S_PAYLOAD: begin
        if (bus.rx_valid) begin
          if (!bus.rx_parity_ok) begin
            frame_err_d = 1'b1;
            state_d     = S_HUNT;
          end else begin
            shadow_d[int'(idx_q)*8 +: 8] = bus.rx_byte;
            csum_d                       = csum_q ^ bus.rx_byte;
            idx_d                        = idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              state_d = S_CHECK;
            end
          end
        end
      end
      S_CHECK: begin
        if (bus.rx_valid) begin
          state_d = S_HUNT;
          if (bus.rx_parity_ok && bus.rx_byte == csum_q) begin
            cmd_valid_d = 1'b1;
            payload_d   = shadow_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = S_HUNT;
    endcase

    // A byte landing on the limit cycle takes priority over the timeout.
    if (!bus.rx_valid && state_q != S_HUNT && tmo_q == TMO_LAST) begin
      frame_err_d = 1'b1;
      state_d     = S_HUNT;
      tmo_d       = '0;
    end

    err_cnt_d = err_cnt_q;
    if (frame_err_d && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end

    busy_d = (state_d != S_HUNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HUNT;
      idx_q       <= '0;
      csum_q      <= '0;
      shadow_q    <= '0;
      tmo_q       <= '0;
      payload_q   <= '0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      shadow_q    <= shadow_d;
      tmo_q       <= tmo_d;
      payload_q   <= payload_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_payload = payload_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.err_count   = err_cnt_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl: good, broadcast, foreign, checksum, timeout, parity, saturation, reset.
module tb_uart_frame_ctrl;

  localparam int TMO = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n_cmd  = 0;
  int   n_err  = 0;
  int   n_both = 0;
  int   c0, e0;

  uart_frame_ctrl_if #(.PAYLOAD_LEN(4)) bus ();

  uart_frame_ctrl #(
    .HEADER      (8'hA5),
    .BOT_ID      (8'h03),
    .PAYLOAD_LEN (4),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.cmd_valid === 1'b1) n_cmd++;
    if (bus.frame_err === 1'b1) n_err++;
    if (bus.cmd_valid === 1'b1 && bus.frame_err === 1'b1) n_both++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before the directed sequence finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic par);
    bus.rx_valid     = 1'b1;
    bus.rx_byte      = b;
    bus.rx_parity_ok = par;
    @(posedge clk);
    #1;
    bus.rx_valid     = 1'b0;
    bus.rx_parity_ok = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] id, input logic [31:0] pl, input logic [7:0] cs);
    send(8'hA5, 1'b1);
    send(id, 1'b1);
    for (int i = 0; i < 4; i++) send(pl[i*8 +: 8], 1'b1);
    send(cs, 1'b1);
  endtask

  initial begin
    bus.rx_valid     = 1'b0;
    bus.rx_byte      = 8'h00;
    bus.rx_parity_ok = 1'b1;
    idle(3);
    rst = 1'b0;
    n_cmd = 0; n_err = 0; n_both = 0;
    chk("rst_cmd_valid", 64'(bus.cmd_valid), 64'd0);
    chk("rst_payload",   64'(bus.cmd_payload), 64'd0);
    chk("rst_frame_err", 64'(bus.frame_err), 64'd0);
    chk("rst_err_count", 64'(bus.err_count), 64'd0);
    chk("rst_busy",      64'(bus.busy), 64'd0);

    // Good frame: checksum 03^10^20^30^40 = 43
    send(8'hA5, 1'b1);
    chk("busy_after_hdr", 64'(bus.busy), 64'd1);
    send(8'h03, 1'b1);
    send(8'h10, 1'b1); send(8'h20, 1'b1); send(8'h30, 1'b1); send(8'h40, 1'b1);
    chk("no_cmd_before_cs", 64'(bus.cmd_valid), 64'd0);
    send(8'h43, 1'b1);
    chk("good_cmd_valid", 64'(bus.cmd_valid), 64'd1);
    chk("good_payload",   64'(bus.cmd_payload), 64'h40302010);
    chk("good_no_err",    64'(bus.frame_err), 64'd0);
    idle(1);
    chk("cmd_valid_one_cycle", 64'(bus.cmd_valid), 64'd0);
    chk("idle_busy", 64'(bus.busy), 64'd0);
    chk("good_pulses", 64'(n_cmd), 64'd1);
    chk("good_err_pulses", 64'(n_err), 64'd0);
    chk("good_err_count", 64'(bus.err_count), 64'd0);

    // Broadcast ID: FF^40 = BF
    send_frame(8'hFF, 32'h40302010, 8'hBF);
    chk("bcast_cmd_valid", 64'(bus.cmd_valid), 64'd1);
    chk("bcast_payload", 64'(bus.cmd_payload), 64'h40302010);
    idle(1);

    // Foreign ID: dropped silently
    c0 = n_cmd; e0 = n_err;
    send(8'hA5, 1'b1);
    send(8'h07, 1'b1);
    chk("foreign_busy", 64'(bus.busy), 64'd0);
    send(8'h11, 1'b1); send(8'h22, 1'b1); send(8'h33, 1'b1); send(8'h44, 1'b1); send(8'h55, 1'b1);
    idle(1);
    chk("foreign_no_cmd", 64'(n_cmd - c0), 64'd0);
    chk("foreign_no_err", 64'(n_err - e0), 64'd0);
    chk("foreign_payload_held", 64'(bus.cmd_payload), 64'h40302010);

    // Bad checksum, then back-to-back good frames (including A5 as payload data)
    send_frame(8'h03, 32'h40302010, 8'h44);
    chk("badcs_frame_err", 64'(bus.frame_err), 64'd1);
    chk("badcs_no_cmd", 64'(bus.cmd_valid), 64'd0);
    chk("badcs_err_count", 64'(bus.err_count), 64'd1);
    chk("badcs_payload_held", 64'(bus.cmd_payload), 64'h40302010);
    send_frame(8'h03, 32'h04030201, 8'h07);
    chk("after_err_cmd", 64'(bus.cmd_valid), 64'd1);
    chk("after_err_payload", 64'(bus.cmd_payload), 64'h04030201);
    send_frame(8'h03, 32'h000000A5, 8'hA6);
    chk("b2b_cmd", 64'(bus.cmd_valid), 64'd1);
    chk("b2b_payload_hdr_data", 64'(bus.cmd_payload), 64'h000000A5);
    idle(1);

    // Timeout after TMO idle cycles
    send(8'hA5, 1'b1); send(8'h03, 1'b1); send(8'h10, 1'b1);
    idle(TMO - 1);
    chk("tmo_not_yet_err", 64'(bus.frame_err), 64'd0);
    chk("tmo_not_yet_busy", 64'(bus.busy), 64'd1);
    idle(1);
    chk("tmo_frame_err", 64'(bus.frame_err), 64'd1);
    chk("tmo_busy", 64'(bus.busy), 64'd0);
    chk("tmo_err_count", 64'(bus.err_count), 64'd2);
    idle(1);

    // Byte exactly on the limit cycle wins
    send(8'hA5, 1'b1); send(8'h03, 1'b1); send(8'h10, 1'b1);
    idle(TMO - 1);
    send(8'h20, 1'b1);
    chk("limit_byte_no_err", 64'(bus.frame_err), 64'd0);
    chk("limit_byte_busy", 64'(bus.busy), 64'd1);
    send(8'h30, 1'b1); send(8'h40, 1'b1); send(8'h43, 1'b1);
    chk("limit_frame_cmd", 64'(bus.cmd_valid), 64'd1);
    chk("limit_err_count", 64'(bus.err_count), 64'd2);
    idle(1);

    // Parity errors
    send(8'hA5, 1'b1); send(8'h03, 1'b1); send(8'h10, 1'b0);
    chk("par_frame_err", 64'(bus.frame_err), 64'd1);
    chk("par_busy", 64'(bus.busy), 64'd0);
    chk("par_err_count", 64'(bus.err_count), 64'd3);
    send(8'hA5, 1'b0);
    chk("par_hdr_hunt_ignored", 64'(bus.busy), 64'd0);
    chk("par_hdr_hunt_no_err", 64'(bus.frame_err), 64'd0);
    send(8'hA5, 1'b1); send(8'h03, 1'b1); send(8'hA5, 1'b0);
    chk("par_a5_payload_err", 64'(bus.frame_err), 64'd1);
    chk("par_a5_not_header", 64'(bus.busy), 64'd0);
    chk("par_err_count2", 64'(bus.err_count), 64'd4);
    idle(1);

    // Saturation
    e0 = n_err;
    for (int k = 0; k < 300; k++) send_frame(8'h03, 32'h40302010, 8'h44);
    idle(1);
    chk("sat_err_count", 64'(bus.err_count), 64'd255);
    chk("sat_err_pulses", 64'(n_err - e0), 64'd300);

    // Reset mid-frame
    send(8'hA5, 1'b1); send(8'h03, 1'b1); send(8'h10, 1'b1); send(8'h20, 1'b1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("mid_rst_cmd_valid", 64'(bus.cmd_valid), 64'd0);
    chk("mid_rst_payload",   64'(bus.cmd_payload), 64'd0);
    chk("mid_rst_frame_err", 64'(bus.frame_err), 64'd0);
    chk("mid_rst_err_count", 64'(bus.err_count), 64'd0);
    chk("mid_rst_busy",      64'(bus.busy), 64'd0);
    send_frame(8'h03, 32'h40302010, 8'h43);
    chk("post_rst_cmd", 64'(bus.cmd_valid), 64'd1);
    chk("post_rst_payload", 64'(bus.cmd_payload), 64'h40302010);
    chk("post_rst_err_count", 64'(bus.err_count), 64'd0);
    idle(2);

    chk("never_cmd_and_err", 64'(n_both), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
Frame-level controller that sits directly behind the UART receiver and sequences its byte stream into robot command frames. Hunts for a header, filters on robot ID, and collects a fixed-length payload. Verifies an XOR checksum and per-byte parity status, then publishes the payload to the motor/command logic with a one-cycle valid strobe. Handles inter-byte timeout and error accounting so downstream logic only ever sees complete, checked frames.

Parameters:
HEADER, 8'hA5, frame start byte
BOT_ID, 8'h03, this robot's ID; 8'hFF is always accepted as broadcast
PAYLOAD_LEN, 4, payload bytes per frame (1..15)
TIMEOUT_CLKS, 1000, max clk cycles between bytes inside a frame (≥2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
rx_valid  in  1  one-cycle pulse: rx_byte/rx_parity_ok valid this cycle
rx_byte  in  8  received byte
rx_parity_ok  in  1  1 = receiver parity check passed for this byte
cmd_valid  out  1  one-cycle pulse: new frame published on cmd_payload
cmd_payload  out  8*PAYLOAD_LEN  last good payload; first payload byte in bits [7:0]
frame_err  out  1  one-cycle pulse on any frame error
err_count  out  8  saturating count of frame errors
busy  out  1  high when state ≠ HUNT

Behaviour:
- Reset (rst=1 at posedge): state=HUNT; cmd_valid=0, cmd_payload=0, frame_err=0, err_count=0, busy=0; shadow buffer, byte index, running checksum, timeout counter cleared. Reset mid-frame discards the partial frame without counting an error.
- States: HUNT, ID, PAYLOAD, CHECK. All transitions occur only on rx_valid cycles, except timeout.
- HUNT: on rx_valid with rx_byte==HEADER and rx_parity_ok=1 -> ID. Any other byte, including a bad-parity byte, is ignored with no error.
- ID: on rx_valid, if rx_byte==BOT_ID or 8'hFF -> PAYLOAD, with checksum=rx_byte and index=0. If the ID mismatches -> HUNT silently (no error; frame belongs to another robot).
- PAYLOAD: each rx_valid writes rx_byte into shadow[index], XORs it into the checksum, and increments index. After byte PAYLOAD_LEN-1 -> CHECK. HEADER value inside the payload is plain data.
- CHECK: on rx_valid, if rx_byte==checksum -> HUNT, and on the next cycle cmd_payload<=shadow and cmd_valid=1 for exactly one cycle (latency: 1 clk after the checksum byte's rx_valid). On mismatch -> HUNT with a frame error.
- Parity: rx_parity_ok=0 on any rx_valid in ID/PAYLOAD/CHECK -> frame error, go to HUNT. The byte is not interpreted, and not re-checked as a header.
- Timeout: the counter clears on every rx_valid and increments each cycle while state≠HUNT. When it reaches TIMEOUT_CLKS-1 with no rx_valid -> frame error, go to HUNT. If rx_valid arrives in the same cycle the counter reaches the limit, the byte wins and no timeout occurs.
- Frame error: frame_err pulses 1 cycle, registered the cycle after detection. err_count increments and saturates at 255 (no wrap).
- cmd_payload holds its value between good frames and is never partially updated. cmd_valid and frame_err are never asserted together.
- Back-to-back: a header may arrive on the cycle immediately after a checksum byte; it must be accepted.
- rx_valid is assumed to be at most 1 per cycle; no backpressure exists.

Test Plan:
- Reset, then bytes A5 03 10 20 30 40 43 -> one cmd_valid pulse 1 clk after 43; cmd_payload=32'h40302010; frame_err never high; err_count=0.
- Broadcast A5 FF 10 20 30 40 BF -> cmd_valid, payload 32'h40302010. Then A5 07 11 22 33 44 xx -> no cmd_valid, no frame_err, payload unchanged.
- A5 03 10 20 30 40 44 (bad checksum) -> frame_err pulse, err_count=1, cmd_payload unchanged. An immediately following valid frame is accepted.
- A5 03 10, then idle for TIMEOUT_CLKS cycles -> frame_err, busy=0. A byte arriving exactly on the limit cycle is accepted instead (no error).
- A5 03 10 with rx_parity_ok=0 on the 3rd byte -> frame_err, return to HUNT. Bad-parity A5 in HUNT is ignored. 300 consecutive bad checksums -> err_count=255.
- rst asserted after A5 03 10 20 -> all outputs 0. A subsequent full frame decodes correctly.
